// File: rtl/vec_result_collector.sv
// Result return path for the vector co-processor: tracks one outstanding length or
// inner-product operation, returns its result over valid/ready. Optional RESULT_COUNT_EN.
module vec_result_collector #(
  parameter int unsigned TIMEOUT          = 1024,
  parameter logic [31:0] TIMEOUT_ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        begin_l,
  input  logic        begin_ip,
  input  logic [3:0]  func,
  input  logic        done_l,
  input  logic [31:0] result_l,
  input  logic        done_ip,
  input  logic [31:0] result_ip,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_tag,
  output logic        res_timeout,
  output logic        busy,
  output logic        err_overlap,
  output logic        err_unexpected,
  input  logic        err_clr,
  output logic [15:0] res_count
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_L, WAIT_IP, HOLD} state_t;

  state_t        state, next_state;
  logic          begin_l_q, begin_ip_q;
  logic [TW-1:0] timer;
  logic          edge_l, edge_ip;
  logic          launch, overlap_evt, unexp_evt, cap_l, cap_ip, cap_to, handshake;

  assign edge_l  = begin_l  & ~begin_l_q;
  assign edge_ip = begin_ip & ~begin_ip_q;

  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_comb begin
    next_state  = state;
    launch      = 1'b0;
    overlap_evt = 1'b0;
    unexp_evt   = 1'b0;
    cap_l       = 1'b0;
    cap_ip      = 1'b0;
    cap_to      = 1'b0;
    handshake   = 1'b0;
    case (state)
      IDLE: begin
        if (edge_l && edge_ip) begin
          overlap_evt = 1'b1;
        end else if (edge_l) begin
          next_state = WAIT_L;
          launch     = 1'b1;
        end else if (edge_ip) begin
          next_state = WAIT_IP;
          launch     = 1'b1;
        end
        unexp_evt = done_l | done_ip;
      end
      WAIT_L: begin
        if (done_l) begin
          cap_l      = 1'b1;
          next_state = HOLD;
        end else if (timer == TIMER_LAST) begin
          cap_to     = 1'b1;
          next_state = HOLD;
        end
        unexp_evt   = done_ip;
        overlap_evt = edge_l | edge_ip;
      end
      WAIT_IP: begin
        if (done_ip) begin
          cap_ip     = 1'b1;
          next_state = HOLD;
        end else if (timer == TIMER_LAST) begin
          cap_to     = 1'b1;
          next_state = HOLD;
        end
        unexp_evt   = done_l;
        overlap_evt = edge_l | edge_ip;
      end
      HOLD: begin
        unexp_evt = done_l | done_ip;
        if (res_ready) begin
          // A launch coinciding with the handshake is taken immediately.
          handshake = 1'b1;
          if (edge_l && edge_ip) begin
            overlap_evt = 1'b1;
            next_state  = IDLE;
          end else if (edge_l) begin
            next_state = WAIT_L;
            launch     = 1'b1;
          end else if (edge_ip) begin
            next_state = WAIT_IP;
            launch     = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else begin
          overlap_evt = edge_l | edge_ip;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      begin_l_q  <= 1'b0;
      begin_ip_q <= 1'b0;
    end else begin
      state      <= next_state;
      begin_l_q  <= begin_l;
      begin_ip_q <= begin_ip;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer          <= '0;
      res_tag        <= '0;
      res_data       <= '0;
      res_timeout    <= 1'b0;
      err_overlap    <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (launch) begin
        res_tag <= func;
        timer   <= '0;
      end else if (state == WAIT_L || state == WAIT_IP) begin
        timer <= timer + TW'(1);
      end
      if (cap_l) begin
        res_data    <= result_l;
        res_timeout <= 1'b0;
      end else if (cap_ip) begin
        res_data    <= result_ip;
        res_timeout <= 1'b0;
      end else if (cap_to) begin
        res_data    <= TIMEOUT_ERR_DATA;
        res_timeout <= 1'b1;
      end
      err_overlap    <= overlap_evt | (err_overlap & ~err_clr);
      err_unexpected <= unexp_evt | (err_unexpected & ~err_clr);
    end
  end

`ifdef RESULT_COUNT_EN
  logic [15:0] count_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else if (handshake) count_q <= count_q + 16'd1;
  end
  assign res_count = count_q;
`else
  assign res_count = '0;
`endif

endmodule

// File: tb/tb_vec_result_collector.sv
// Scoreboard bench for vec_result_collector with TIMEOUT=8; expected results are
// queued at stimulus time and compared at each handshake.
module tb_vec_result_collector;

  logic        clock = 1'b0;
  logic        reset_n, begin_l, begin_ip, done_l, done_ip, res_ready, err_clr;
  logic [3:0]  func;
  logic [31:0] result_l, result_ip;
  logic        res_valid, res_timeout, busy, err_overlap, err_unexpected;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic [15:0] res_count;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        to;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned exp_count = 0;

  vec_result_collector #(.TIMEOUT(8), .TIMEOUT_ERR_DATA(32'hFFFF_FFFF)) dut (
    .clock(clock), .reset_n(reset_n), .begin_l(begin_l), .begin_ip(begin_ip),
    .func(func), .done_l(done_l), .result_l(result_l), .done_ip(done_ip),
    .result_ip(result_ip), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_timeout(res_timeout),
    .busy(busy), .err_overlap(err_overlap), .err_unexpected(err_unexpected),
    .err_clr(err_clr), .res_count(res_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_front(input string name);
    exp_t e;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty at result", name);
      return;
    end
    e = q.pop_front();
    total++;
    if (res_data !== e.data) begin
      bad++; $display("FAIL %s data: got %h expected %h", name, res_data, e.data);
    end
    total++;
    if (res_tag !== e.tag) begin
      bad++; $display("FAIL %s tag: got %h expected %h", name, res_tag, e.tag);
    end
    total++;
    if (res_timeout !== e.to) begin
      bad++; $display("FAIL %s timeout: got %b expected %b", name, res_timeout, e.to);
    end
  endtask

  task automatic collect(input string name);
    int unsigned n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (res_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s wait: res_valid=%b expected 1 within 40 cycles", name, res_valid);
      void'(q.pop_front());
      return;
    end
    compare_front(name);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_count++;
    total++;
    if (res_valid !== 1'b0) begin
      bad++; $display("FAIL %s release: res_valid=%b expected 0", name, res_valid);
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef RESULT_COUNT_EN
    return 16'(exp_count);
`else
    return 16'd0;
`endif
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; begin_l = 0; begin_ip = 0; done_l = 0; done_ip = 0;
    res_ready = 0; err_clr = 0; func = '0; result_l = '0; result_ip = '0;
    exp_count = 0;
    #12;
    chk("reset valid", {31'd0, res_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset data", res_data, 32'd0);
    chk("reset tag/to/errs", {25'd0, res_tag, res_timeout, err_overlap, err_unexpected}, 32'd0);
    chk("reset count", {16'd0, res_count}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_length();
    func = 4'b1000; begin_l = 1'b1;
    tick();
    chk("len busy", {31'd0, busy}, 32'd1);
    q.push_back('{32'h5, 4'b1000, 1'b0});
    tick(); tick();
    done_l = 1'b1; result_l = 32'h5;
    tick();
    done_l = 1'b0; result_l = 32'hDEAD_BEEF;
    chk("len valid latency", {31'd0, res_valid}, 32'd1);
    tick(); tick();
    chk("len held valid", {31'd0, res_valid}, 32'd1);
    chk("len held data", res_data, 32'h5);
    collect("len");
    begin_l = 1'b0;
    tick();
    chk("len idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_timeout();
    func = 4'b1111; begin_ip = 1'b1;
    tick();
    q.push_back('{32'hFFFF_FFFF, 4'b1111, 1'b1});
    repeat (7) tick();
    chk("to not early", {31'd0, res_valid}, 32'd0);
    tick();
    chk("to valid at N+8", {31'd0, res_valid}, 32'd1);
    collect("timeout");
    begin_ip = 1'b0;
    tick();
  endtask

  task automatic test_unexpected();
    func = 4'b0011; begin_ip = 1'b1;
    tick();
    done_l = 1'b1; result_l = 32'h9999;
    tick();
    done_l = 1'b0;
    chk("unexp flag", {31'd0, err_unexpected}, 32'd1);
    chk("unexp still waiting", {30'd0, busy, res_valid}, 32'b10);
    done_ip = 1'b1; result_ip = 32'h1234;
    q.push_back('{32'h1234, 4'b0011, 1'b0});
    tick();
    done_ip = 1'b0;
    collect("ip");
    err_clr = 1'b1; done_l = 1'b1;
    tick();
    done_l = 1'b0;
    chk("unexp set wins over clr", {31'd0, err_unexpected}, 32'd1);
    tick();
    err_clr = 1'b0;
    chk("unexp cleared", {31'd0, err_unexpected}, 32'd0);
    begin_ip = 1'b0;
    tick();
  endtask

  task automatic test_overlap_hold();
    func = 4'b0010; begin_l = 1'b1;
    tick();
    begin_l = 1'b0; done_l = 1'b1; result_l = 32'hAA;
    q.push_back('{32'hAA, 4'b0010, 1'b0});
    tick();
    done_l = 1'b0;
    func = 4'b0110; begin_l = 1'b1;
    tick();
    chk("hold overlap flag", {31'd0, err_overlap}, 32'd1);
    chk("hold tag kept", {28'd0, res_tag}, 32'h2);
    collect("hold drop");
    chk("hold dropped idle", {31'd0, busy}, 32'd0);
    begin_l = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    func = 4'b0010; begin_l = 1'b1;
    tick();
    begin_l = 1'b0; done_l = 1'b1; result_l = 32'hBB;
    q.push_back('{32'hBB, 4'b0010, 1'b0});
    tick();
    done_l = 1'b0;
    compare_front("hs relaunch");
    func = 4'b0111; begin_l = 1'b1; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_count++;
    chk("hs relaunch state", {28'd0, res_tag, busy, res_valid, err_overlap}, {28'd0, 4'b0111, 3'b100} >> 0);
    done_l = 1'b1; result_l = 32'h77;
    q.push_back('{32'h77, 4'b0111, 1'b0});
    tick();
    done_l = 1'b0; begin_l = 1'b0;
    collect("relaunched");
  endtask

  task automatic test_both_edges();
    begin_l = 1'b1; begin_ip = 1'b1; func = 4'b0101;
    tick();
    chk("both overlap", {31'd0, err_overlap}, 32'd1);
    chk("both stay idle", {31'd0, busy}, 32'd0);
    begin_l = 1'b0; begin_ip = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("overlap cleared", {31'd0, err_overlap}, 32'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      func = 4'(i); begin_l = 1'b1;
      tick();
      begin_l = 1'b0; done_l = 1'b1; result_l = 32'(i * 3);
      q.push_back('{32'(i * 3), 4'(i), 1'b0});
      tick();
      done_l = 1'b0;
      collect("b2b");
    end
    chk("count", {16'd0, res_count}, {16'd0, exp_cnt()});
  endtask

  task automatic test_reset_mid();
    func = 4'b1001; begin_l = 1'b1;
    tick();
    chk("mid busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    exp_count = 0;
    #1;
    chk("mid reset outputs", {25'd0, res_tag, busy, res_valid, res_timeout},
        32'd0);
    chk("mid reset count", {16'd0, res_count}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("mid relaunch", {27'd0, res_tag, busy}, {27'd0, 4'b1001, 1'b1});
    done_l = 1'b1; result_l = 32'h55;
    q.push_back('{32'h55, 4'b1001, 1'b0});
    tick();
    done_l = 1'b0; begin_l = 1'b0;
    collect("after reset");
    chk("count after reset", {16'd0, res_count}, {16'd0, exp_cnt()});
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_length();
    test_timeout();
    test_unexpected();
    test_overlap_hold();
    test_both_edges();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
